mab_seq: RTL
============

Name: mab_seq

Overview:
- Parametrised successor to the fixed five-input memory-address-bus source mux.
- Selects one of NSRC address sources and registers the chosen address onto the MAB.
- Sequences the memory access with configurable wait states, a source-ready wait with timeout, and word-alignment checking.
- Returns a single-cycle done/error handshake to the control unit.

Parameters:
AW, 16, address width in bits
NSRC, 5, number of address sources (index 0 = PC, also the fallback source)
SELW, 3, select width; requires 2^SELW >= NSRC
WAIT_STATES, 0, extra memory cycles per access (0..15)
SRC_TIMEOUT, 8, max cycles to wait for src_valid before aborting (>=1)

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous active-high reset
req  in  1  start access; sampled only in IDLE
sel  in  SELW  source index, latched with req
rw  in  1  1 = write, 0 = read; latched with req
bw  in  1  1 = byte, 0 = word; latched with req
src_addr  in  NSRC*AW  flattened sources; source i occupies bits [i*AW +: AW]
src_valid  in  NSRC  per-source address-ready flag (e.g. address calculator done)
mab_out  out  AW  registered memory address
mem_en  out  1  memory strobe, high during ACCESS
mem_we  out  1  write strobe, equals mem_en AND latched rw
busy  out  1  high in any state except IDLE
done  out  1  one-cycle pulse at end of every accepted request
align_err  out  1  one-cycle pulse with done; word access to odd address
timeout_err  out  1  one-cycle pulse with done; source never became valid

Behaviour:
- Reset (rst=1 at an edge, overrides everything including mid-access):
  - state IDLE; mab_out = 0; mem_en, mem_we, busy, done, align_err, timeout_err = 0
  - wait and timeout counters cleared
- States: IDLE, WAIT_SRC, ACCESS, DONE.
- Source selection:
  - Effective index = sel if sel < NSRC, else 0; latched on acceptance.
  - src_valid and src_addr are read live from that index thereafter.
- IDLE:
  - On req=1: latch index/rw/bw and clear the timeout counter.
  - If the source is valid that cycle, go to ACCESS; otherwise go to WAIT_SRC.
- WAIT_SRC:
  - Timeout counter increments each cycle; mab_out holds its previous value.
  - If src_valid[idx]=1, go to ACCESS.
  - Else, when the counter reaches SRC_TIMEOUT, go to DONE with timeout_err set and no memory strobe.
  - Valid and timeout in the same cycle: valid wins.
- Entry to ACCESS, on the transition edge:
  - mab_out <= src_addr[idx]; mem_en = 1 from the next cycle.
  - If bw=0 and address bit 0 = 1, mab_out bit 0 is forced to 0 and the align_err flag is latched; the access still proceeds.
- ACCESS:
  - Lasts exactly WAIT_STATES+1 cycles, with mem_en=1 and mem_we=rw throughout.
  - mab_out is stable; changes on src_addr are ignored.
- DONE:
  - Exactly one cycle: done=1, plus align_err/timeout_err if latched; mem_en=0.
  - Flags clear; next state IDLE.
- Latency, req to done: valid source = WAIT_STATES+3 cycles (IDLE, ACCESS×(WS+1), DONE).
- req outside IDLE is ignored (no queuing); the requester must hold or reissue it after done.
- Back-to-back: req in the IDLE cycle following DONE is accepted, giving a minimum one idle cycle between accesses.
- mab_out retains the last address after done until the next ACCESS entry.

Test Plan:
- Reset mid-access: WAIT_STATES=2, issue req; assert rst during the 2nd ACCESS cycle -> next cycle mab_out=0, mem_en=0, busy=0; no done pulse.
- Basic read: WAIT_STATES=0, req sel=0 rw=0 bw=0, src0=0xF800 valid -> mab_out=0xF800, mem_en high 1 cycle, mem_we=0, done at cycle 3, no errors.
- Wait states and write: WAIT_STATES=3, sel=1 rw=1, src1=0x0200 -> mem_en and mem_we high exactly 4 cycles; done at cycle 6.
- Source wait: sel=2, src_valid[2] rises 3 cycles after req, src2=0x1234 -> busy throughout, mab_out=0x1234 after valid, done follows; no timeout_err.
- Timeout and fallback:
  - sel=2 with src_valid[2] held 0, SRC_TIMEOUT=8 -> done and timeout_err together, mem_en never high.
  - sel=6 (>=NSRC) -> PC source used.
- Alignment: bw=0 src=0x0201 -> mab_out=0x0200, align_err with done; bw=1 same address -> mab_out=0x0201, no align_err.

Source files
------------

// File: rtl/mab_seq.sv
// Memory-address-bus sequencer: picks one of NSRC address sources, registers it
// onto the MAB and runs a strobed access with wait states, source timeout and alignment check.
module mab_seq #(
  parameter int AW          = 16,
  parameter int NSRC        = 5,
  parameter int SELW        = 3,
  parameter int WAIT_STATES = 0,
  parameter int SRC_TIMEOUT = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req,
  input  logic [SELW-1:0]    sel,
  input  logic               rw,
  input  logic               bw,
  input  logic [NSRC*AW-1:0] src_addr,
  input  logic [NSRC-1:0]    src_valid,
  output logic [AW-1:0]      mab_out,
  output logic               mem_en,
  output logic               mem_we,
  output logic               busy,
  output logic               done,
  output logic               align_err,
  output logic               timeout_err,
  output logic [1:0]         state_dbg
);

  typedef enum logic [1:0] {IDLE, WAIT_SRC, ACCESS, DONE} state_t;

  localparam int TW = (SRC_TIMEOUT > 1) ? $clog2(SRC_TIMEOUT) : 1;
  localparam logic [TW-1:0] TLIM1 = TW'(SRC_TIMEOUT - 1);
  localparam logic [3:0]    WLIM  = 4'(WAIT_STATES);

  state_t          state;
  logic [SELW-1:0] idx;
  logic            rw_q;
  logic            bw_q;
  logic            al_q;
  logic [TW-1:0]   tcnt;
  logic [3:0]      wcnt;

  logic [SELW-1:0] eff_sel;
  logic [SELW-1:0] src_idx;
  logic            live_valid;
  logic [AW-1:0]   live_addr;
  logic            rw_cur;
  logic            bw_cur;
  logic            start_access;

  // Out-of-range selects fall back to the PC source; in IDLE the live inputs
  // are used because the latched copies are only written on the accepting edge.
  assign eff_sel      = ({1'b0, sel} < (SELW+1)'(NSRC)) ? sel : '0;
  assign src_idx      = (state == IDLE) ? eff_sel : idx;
  assign live_valid   = src_valid[src_idx];
  assign live_addr    = src_addr[src_idx*AW +: AW];
  assign rw_cur       = (state == IDLE) ? rw : rw_q;
  assign bw_cur       = (state == IDLE) ? bw : bw_q;
  assign start_access = live_valid && (((state == IDLE) && req) || (state == WAIT_SRC));
  assign state_dbg    = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      idx         <= '0;
      rw_q        <= 1'b0;
      bw_q        <= 1'b0;
      al_q        <= 1'b0;
      tcnt        <= '0;
      wcnt        <= '0;
      mab_out     <= '0;
      mem_en      <= 1'b0;
      mem_we      <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      align_err   <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      done        <= 1'b0;
      align_err   <= 1'b0;
      timeout_err <= 1'b0;
      case (state)
        IDLE: begin
          if (req) begin
            idx   <= eff_sel;
            rw_q  <= rw;
            bw_q  <= bw;
            tcnt  <= '0;
            busy  <= 1'b1;
            state <= live_valid ? ACCESS : WAIT_SRC;
          end
        end
        WAIT_SRC: begin
          tcnt <= tcnt + 1'b1;
          // A source turning valid on the last allowed cycle still wins.
          if (live_valid) begin
            state <= ACCESS;
          end else if (tcnt == TLIM1) begin
            state       <= DONE;
            done        <= 1'b1;
            timeout_err <= 1'b1;
          end
        end
        ACCESS: begin
          if (wcnt == WLIM) begin
            state     <= DONE;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            done      <= 1'b1;
            align_err <= al_q;
          end else begin
            wcnt <= wcnt + 4'd1;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
          al_q  <= 1'b0;
        end
        default: state <= IDLE;
      endcase

      // Word accesses to odd addresses are forced even but still performed.
      if (start_access) begin
        mab_out <= {live_addr[AW-1:1], live_addr[0] & bw_cur};
        al_q    <= ~bw_cur & live_addr[0];
        wcnt    <= '0;
        mem_en  <= 1'b1;
        mem_we  <= rw_cur;
      end
    end
  end

endmodule
